// File: rtl/dec_digit_emit.sv
// dec_digit_emit: converts a binary value to BCD (double-dabble, one bit/cycle) and streams len digits MSD-first
// Optional feature macro: ASCII_OUT_EN (digit[7:4]=4'h3 for ASCII '0'..'9'; otherwise raw BCD)
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    input handshake; in_ready only while idle and not in reset
//   in, len              binary value and its decimal digit count
//   dig_valid/dig_ready  digit handshake
//   digit                [3:0] BCD digit, [7:4] encoding prefix
//   dig_last             marks the least significant digit
//   busy                 converting or emitting
module dec_digit_emit #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10,
    parameter int LEN_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in,
    input  logic [LEN_W-1:0] len,
    output logic             dig_valid,
    input  logic             dig_ready,
    output logic [7:0]       digit,
    output logic             dig_last,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam int BW = 4 * DIGITS;
`ifdef ASCII_OUT_EN
    localparam logic [3:0] HI = 4'h3;
`else
    localparam logic [3:0] HI = 4'h0;
`endif
    typedef enum logic [1:0] {IDLE, CONV, EMIT} state_t;
    state_t state, state_d;
    logic [WIDTH-1:0] val;
    logic [BW-1:0] bcd, adj;
    logic [CW-1:0] cnt;
    logic [LEN_W-1:0] idx, len_eff;
    logic [3:0] nib;
    always_comb begin
        adj = bcd;
        for (int i = 0; i < DIGITS; i++)
            adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
    always_comb begin
        len_eff = len == '0 ? LEN_W'(1) : len > LEN_W'(DIGITS) ? LEN_W'(DIGITS) : len;
        nib = bcd[{idx, 2'b00} +: 4];
        state_d = state == IDLE ? (in_valid ? CONV : IDLE) :
                  state == CONV ? (cnt == CW'(WIDTH - 1) ? EMIT : CONV) :
                  (dig_ready && idx == '0 ? IDLE : EMIT);
        in_ready = state == IDLE && !rst;
        dig_valid = state == EMIT;
        busy = state != IDLE;
        digit = dig_valid ? {HI, nib} : 8'h00;
        dig_last = dig_valid && idx == '0;
    end
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_d;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            val <= '0;
            bcd <= '0;
            cnt <= '0;
            idx <= '0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                val <= in;
                bcd <= '0;
                cnt <= '0;
                idx <= len_eff - LEN_W'(1);
            end
        end else if (state == CONV) begin
            // add-3 correction first, then shift the next value bit into the BCD LSB
            bcd <= {adj[BW-2:0], val[WIDTH-1]};
            val <= val << 1;
            cnt <= cnt + CW'(1);
        end else if (dig_ready && idx != '0) begin
            idx <= idx - LEN_W'(1);
        end
    end
endmodule
